// File: rtl/mips_div.sv
// rtl/mips_div.sv - radix-2 restoring divider for the MIPS EX stage (optional DIV_ZERO_FLAG_EN adds div_zero_o)
module mips_div #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic                 div_zero_o
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

    typedef enum logic [1:0] {
        ST_FREE    = 2'd0,
        ST_DIVZERO = 2'd1,
        ST_ON      = 2'd2,
        ST_END     = 2'd3
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   dvs_q;
    logic               sign1_q;
    logic               sign2_q;
    logic [2*WIDTH-1:0] result_q;
    logic               ready_q;
`ifdef DIV_ZERO_FLAG_EN
    logic               div_zero_q;
`endif

    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   quo_d;
    logic               op1_neg;
    logic               op2_neg;
    logic [WIDTH-1:0]   op1_abs;
    logic [WIDTH-1:0]   op2_abs;
    logic [WIDTH-1:0]   rem_final;
    logic [WIDTH-1:0]   quo_final;

    // Operand magnitudes and the final sign correction of the result
    always_comb begin
        op1_neg   = signed_div_i & opdata1_i[WIDTH-1];
        op2_neg   = signed_div_i & opdata2_i[WIDTH-1];
        op1_abs   = op1_neg ? (~opdata1_i + ONE_W) : opdata1_i;
        op2_abs   = op2_neg ? (~opdata2_i + ONE_W) : opdata2_i;
        // Remainder takes the dividend's sign; quotient is negative when signs differ
        rem_final = sign1_q ? (~rem_q + ONE_W) : rem_q;
        quo_final = (sign1_q ^ sign2_q) ? (~quo_q + ONE_W) : quo_q;
    end

    // One restoring step: shift the next dividend bit in and try to subtract the divisor
    always_comb begin
        trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
        rem_d = rem_q;
        quo_d = quo_q;
        if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Divider control FSM with registered result and handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FREE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            sign1_q    <= 1'b0;
            sign2_q    <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            div_zero_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_FREE: begin
                    // A request raised together with annul is simply not taken
                    if (start_i && !annul_i) begin
                        cnt_q <= '0;
                        if (opdata2_i == '0) begin
                            state_q <= ST_DIVZERO;
                        end else begin
                            state_q <= ST_ON;
                            sign1_q <= op1_neg;
                            sign2_q <= op2_neg;
                            quo_q   <= op1_abs;
                            dvs_q   <= op2_abs;
                            rem_q   <= '0;
                        end
                    end
                end
                ST_DIVZERO: begin
                    // Dwell two cycles so ready rises on the second edge after the request
                    if (cnt_q == '0) begin
                        cnt_q <= CNT_ONE;
                    end else begin
                        state_q    <= ST_END;
                        result_q   <= '0;
                        ready_q    <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
                        div_zero_q <= 1'b1;
`endif
                    end
                end
                ST_ON: begin
                    if (annul_i) begin
                        state_q <= ST_FREE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q  <= ST_END;
                        result_q <= {rem_final, quo_final};
                        ready_q  <= 1'b1;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_END: begin
                    // Result is held until EX drops start; a late flush cannot undo it
                    if (!start_i) begin
                        state_q    <= ST_FREE;
                        result_q   <= '0;
                        ready_q    <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
                        div_zero_q <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q <= ST_FREE;
                end
            endcase
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
`ifdef DIV_ZERO_FLAG_EN
    assign div_zero_o = div_zero_q;
`endif

endmodule

// File: tb/tb_mips_div.sv
// tb/tb_mips_div.sv - directed self-checking bench for mips_div
module tb_mips_div;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           signed_div;
    logic [W-1:0]   op1;
    logic [W-1:0]   op2;
    logic           start;
    logic           annul;
    logic [2*W-1:0] result;
    logic           ready;
`ifdef DIV_ZERO_FLAG_EN
    logic           div_zero;
`endif

    int checks = 0;
    int errors = 0;

    mips_div #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
`ifdef DIV_ZERO_FLAG_EN
        ,
        .div_zero_o   (div_zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue a divide with start held, measure latency, check hold and release
    task automatic run_div(input string tag, input logic sgn, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [2*W-1:0] exp_res,
                           input int exp_lat, input logic exp_dz);
        int lat;
        lat = -1;
        @(negedge clk);
        signed_div = sgn;
        op1        = a;
        op2        = b;
        annul      = 1'b0;
        start      = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                lat = k;
                break;
            end
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_res"}, result, exp_res);
`ifdef DIV_ZERO_FLAG_EN
        check({tag, "_dz"}, 64'(div_zero), 64'(exp_dz));
`else
        if (exp_dz) checks = checks + 0;
`endif
        // Still held after a few more cycles with start high and a stray annul
        @(negedge clk);
        annul = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_hold"}, {result[2*W-2:0], ready}, {exp_res[2*W-2:0], 1'b1});
        @(negedge clk);
        annul = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_rel"}, {result[2*W-2:0], ready}, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
        check({tag, "_reldz"}, 64'(div_zero), 64'd0);
`endif
    endtask

    initial begin
        int seen;
        rst        = 1'b1;
        signed_div = 1'b0;
        op1        = '0;
        op2        = '0;
        start      = 1'b0;
        annul      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", {result[2*W-2:0], ready}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div("u100_7",  1'b0, 32'd100,        32'd7,        {32'h2, 32'hE},               33, 1'b0);
        run_div("s_m7_2",  1'b1, 32'hFFFF_FFF9,  32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 1'b0);
        run_div("u_m7_2",  1'b0, 32'hFFFF_FFF9,  32'd2,        {32'h1, 32'h7FFF_FFFC},       33, 1'b0);
        run_div("s5_0",    1'b1, 32'd5,          32'd0,        64'd0,                        2,  1'b1);
        run_div("u5_0",    1'b0, 32'd5,          32'd0,        64'd0,                        2,  1'b1);

        // Annul at iteration 10: start dropped with the flush, no result ever appears
        @(negedge clk);
        signed_div = 1'b0;
        op1        = 32'd1000;
        op2        = 32'd3;
        start      = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        start = 1'b0;
        @(negedge clk);
        annul = 1'b0;
        seen  = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (ready || result != '0) seen = 1;
        end
        check("annul_noready", 64'(seen), 64'd0);
        run_div("u_ffff_10", 1'b0, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, 33, 1'b0);

        // Reset at iteration 20 clears everything on the next edge
        @(negedge clk);
        signed_div = 1'b0;
        op1        = 32'd12345;
        op2        = 32'd11;
        start      = 1'b1;
        repeat (21) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid", {result[2*W-2:0], ready}, 64'd0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        run_div("u9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 1'b0);

        // start with annul in FREE is ignored; latency of the next request is unchanged
        @(negedge clk);
        signed_div = 1'b1;
        op1        = 32'h8000_0000;
        op2        = 32'hFFFF_FFFF;
        start      = 1'b1;
        annul      = 1'b1;
        seen       = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (ready) seen = 1;
        end
        check("free_annul", 64'(seen), 64'd0);
        run_div("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
